// File: rtl/rgb2ycbcr_csc.sv
// rgb2ycbcr_csc: 3-stage RGB->YCbCr converter (BT.601/BT.709 full range)
// with a bypass mode. Ports: clk, rst (sync, active-high), mode_in,
// de/hsync/vsync, pixel_in {R,G,B} -> de/hsync/vsync_out,
// pixel_out {Y,Cb,Cr} (or {R,G,B} in bypass), mode_active.
// Optional macro CSC_RANGE_LIMIT_EN clamps converted outputs to studio range.
module rgb2ycbcr_csc #(
   parameter int         DATA_W       = 8,
   parameter logic [1:0] MODE_DEFAULT = 2'd0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            mode_in,
   input  logic                  de,
   input  logic                  hsync,
   input  logic                  vsync,
   input  logic [3*DATA_W-1:0]   pixel_in,
   output logic                  de_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic [3*DATA_W-1:0]   pixel_out,
   output logic [1:0]            mode_active
);

   localparam int PW = DATA_W + 10;
   localparam int SW = DATA_W + 12;

   localparam logic signed [SW-1:0] RND = SW'(128);
   localparam logic signed [SW-1:0] C0  = SW'(1) << (DATA_W + 7);

`ifdef CSC_RANGE_LIMIT_EN
   localparam logic [DATA_W-1:0] LO   = DATA_W'(16  << (DATA_W - 8));
   localparam logic [DATA_W-1:0] HI_Y = DATA_W'(235 << (DATA_W - 8));
   localparam logic [DATA_W-1:0] HI_C = DATA_W'(240 << (DATA_W - 8));
`else
   localparam logic [DATA_W-1:0] LO   = '0;
   localparam logic [DATA_W-1:0] HI_Y = '1;
   localparam logic [DATA_W-1:0] HI_C = '1;
`endif

   // Row-major coefficient table: k = 3*row + col, rows Y/Cb/Cr, cols R/G/B.
   function automatic logic signed [8:0] coef(input logic bt709,
                                              input int   k);
      logic signed [8:0] c;
      unique case (k)
         0:       c = bt709 ?  9'sd54  :  9'sd77;
         1:       c = bt709 ?  9'sd183 :  9'sd150;
         2:       c = bt709 ?  9'sd19  :  9'sd29;
         3:       c = bt709 ? -9'sd29  : -9'sd43;
         4:       c = bt709 ? -9'sd99  : -9'sd85;
         5:       c = 9'sd128;
         6:       c = 9'sd128;
         7:       c = bt709 ? -9'sd116 : -9'sd107;
         8:       c = bt709 ? -9'sd12  : -9'sd21;
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] clamp(
      input logic signed [SW-1:0] v,
      input logic [DATA_W-1:0]    lo,
      input logic [DATA_W-1:0]    hi
   );
      logic signed [SW-1:0] s;
      logic [DATA_W-1:0]    r;
      s = v >>> 8;
      if (s < $signed(SW'(lo)))      r = lo;
      else if (s > $signed(SW'(hi))) r = hi;
      else                           r = s[DATA_W-1:0];
      return r;
   endfunction

   // Stage 1: frame-start mode capture and products
   logic                 vs_prev;
   logic                 frame_start;
   logic [1:0]           mode_sel;
   logic [DATA_W-1:0]    comp [3];
   logic signed [PW-1:0] prod [9];

   // The edge-cycle pixel already uses the newly requested mode.
   assign frame_start = vsync & ~vs_prev;
   assign mode_sel    = frame_start ? mode_in : mode_active;

   assign comp[0] = pixel_in[3*DATA_W-1 -: DATA_W];
   assign comp[1] = pixel_in[2*DATA_W-1 -: DATA_W];
   assign comp[2] = pixel_in[DATA_W-1   -: DATA_W];

   always_comb begin
      for (int j = 0; j < 3; j++) begin
         for (int k = 0; k < 3; k++) begin
            prod[3*j+k] = $signed(PW'({1'b0, comp[k]}))
                        * PW'(coef(mode_sel[0], 3*j+k));
         end
      end
   end

   logic signed [PW-1:0] s1_prod [9];
   logic [3*DATA_W-1:0]  s1_pix;
   logic                 s1_byp;
   logic                 s1_live;
   logic [2:0]           s1_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev     <= 1'b0;
         mode_active <= MODE_DEFAULT;
         s1_pix      <= '0;
         s1_byp      <= 1'b0;
         s1_live     <= 1'b0;
         s1_sync     <= '0;
         for (int i = 0; i < 9; i++) s1_prod[i] <= '0;
      end else begin
         vs_prev     <= vsync;
         mode_active <= mode_sel;
         s1_pix      <= pixel_in;
         s1_byp      <= mode_sel[1];
         s1_live     <= 1'b1;
         s1_sync     <= {de, hsync, vsync};
         for (int i = 0; i < 9; i++) s1_prod[i] <= prod[i];
      end
   end

   // Stage 2: sums with chroma offset and rounding
   logic signed [SW-1:0] sum [3];

   always_comb begin
      for (int j = 0; j < 3; j++) begin
         sum[j] = SW'(s1_prod[3*j])
                + SW'(s1_prod[3*j+1])
                + SW'(s1_prod[3*j+2])
                + RND;
         if (j != 0) sum[j] = sum[j] + C0;
      end
   end

   logic signed [SW-1:0] s2_sum [3];
   logic [3*DATA_W-1:0]  s2_pix;
   logic                 s2_byp;
   logic                 s2_live;
   logic [2:0]           s2_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_pix  <= '0;
         s2_byp  <= 1'b0;
         s2_live <= 1'b0;
         s2_sync <= '0;
         for (int j = 0; j < 3; j++) s2_sum[j] <= '0;
      end else begin
         s2_pix  <= s1_pix;
         s2_byp  <= s1_byp;
         s2_live <= s1_live;
         s2_sync <= s1_sync;
         for (int j = 0; j < 3; j++) s2_sum[j] <= sum[j];
      end
   end

   // Stage 3: scale, clamp, output. Flushed slots after reset stay zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_out    <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         pixel_out <= '0;
      end else begin
         {de_out, hsync_out, vsync_out} <= s2_sync;
         if (!s2_live)
            pixel_out <= '0;
         else if (s2_byp)
            pixel_out <= s2_pix;
         else
            pixel_out <= {clamp(s2_sum[0], LO, HI_Y),
                          clamp(s2_sum[1], LO, HI_C),
                          clamp(s2_sum[2], LO, HI_C)};
      end
   end

endmodule

// File: tb/tb_rgb2ycbcr_csc.sv
// tb_rgb2ycbcr_csc: table vectors, hand sequences and random stimulus
// against an arithmetic reference model of the colour converter.
module tb_rgb2ycbcr_csc;

   localparam int DATA_W = 8;
`ifdef CSC_RANGE_LIMIT_EN
   localparam int LO   = 16;
   localparam int HI_Y = 235;
   localparam int HI_C = 240;
`else
   localparam int LO   = 0;
   localparam int HI_Y = 255;
   localparam int HI_C = 255;
`endif

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic [1:0]  mode_in  = 2'd0;
   logic        de       = 1'b0;
   logic        hsync    = 1'b0;
   logic        vsync    = 1'b0;
   logic [23:0] pixel_in = '0;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;
   logic [23:0] pixel_out;
   logic [1:0]  mode_active;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [2:0]  sync;
      logic [23:0] pix;
   } exp_t;

   typedef struct packed {
      logic [1:0]  mode;
      logic [23:0] pix;
      logic [23:0] expv;
   } vec_t;

   exp_t       q[$];
   logic [1:0] m_mode;
   logic       m_prev;

   int k601 [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
   int k709 [9] = '{54, 183, 19, -29, -99, 128, 128, -116, -12};

   always #5 clk = ~clk;

   rgb2ycbcr_csc #(.DATA_W(DATA_W), .MODE_DEFAULT(2'd0)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode_in    (mode_in),
      .de         (de),
      .hsync      (hsync),
      .vsync      (vsync),
      .pixel_in   (pixel_in),
      .de_out     (de_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .pixel_out  (pixel_out),
      .mode_active(mode_active)
   );

   function automatic int clampi(int v, int lo, int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic logic [23:0] model(logic [1:0] m, logic [23:0] p);
      int c [3];
      int res [3];
      int acc;
      if (m[1]) return p;
      c[0] = int'(p[23:16]);
      c[1] = int'(p[15:8]);
      c[2] = int'(p[7:0]);
      for (int j = 0; j < 3; j++) begin
         acc = (j == 0) ? 128 : 128 + 32768;
         for (int k = 0; k < 3; k++)
            acc += (m[0] ? k709[3*j+k] : k601[3*j+k]) * c[k];
         res[j] = clampi(acc >>> 8, LO, (j == 0) ? HI_Y : HI_C);
      end
      return {8'(res[0]), 8'(res[1]), 8'(res[2])};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // One clock: predict this cycle's input, clock, then score outputs.
   task automatic cycle();
      exp_t       e;
      exp_t       z;
      logic [1:0] eff;
      z = '0;
      if (rst) begin
         @(posedge clk);
         #1;
         q.delete();
         q.push_back(z);
         q.push_back(z);
         m_mode = 2'd0;
         m_prev = 1'b0;
         chk("rst pixel", 32'(pixel_out), 32'h0);
         chk("rst sync", 32'({de_out, hsync_out, vsync_out}), 32'h0);
         chk("rst mode", 32'(mode_active), 32'h0);
         return;
      end
      eff    = (vsync && !m_prev) ? mode_in : m_mode;
      e.pix  = model(eff, pixel_in);
      e.sync = {de, hsync, vsync};
      q.push_back(e);
      @(posedge clk);
      #1;
      m_mode = eff;
      m_prev = vsync;
      chk("mode_active", 32'(mode_active), 32'(m_mode));
      if (q.size() >= 3) begin
         e = q.pop_front();
         chk("sb pixel", 32'(pixel_out), 32'(e.pix));
         chk("sb sync", 32'({de_out, hsync_out, vsync_out}), 32'(e.sync));
      end
   endtask

   task automatic apply_vec(input vec_t v);
      vsync    = 1'b0;
      de       = 1'b0;
      hsync    = 1'b0;
      pixel_in = '0;
      mode_in  = v.mode;
      cycle();
      vsync    = 1'b1;
      de       = 1'b1;
      hsync    = 1'b1;
      pixel_in = v.pix;
      cycle();
      cycle();
      cycle();
      chk("vec pixel", 32'(pixel_out), 32'(v.expv));
      chk("vec sync", 32'({de_out, hsync_out, vsync_out}), 32'h7);
      chk("vec mode", 32'(mode_active), 32'(v.mode));
   endtask

   localparam logic [23:0] P     = 24'h80FF1C;
   localparam logic [23:0] P601  = {8'd191, 8'd36, 8'd83};
   localparam logic [23:0] P709  = {8'd211, 8'd29, 8'd75};

   vec_t tbl [10];

   initial begin
      tbl[0] = '{2'd0, P, P601};
      tbl[1] = '{2'd1, P, P709};
      tbl[2] = '{2'd2, P, P};
      tbl[3] = '{2'd3, P, P};
      tbl[4] = '{2'd0, 24'hFFFFFF, {8'(HI_Y), 8'd128, 8'd128}};
      tbl[5] = '{2'd0, 24'h000000, {8'(LO), 8'd128, 8'd128}};
      tbl[6] = '{2'd1, 24'hFFFFFF, {8'(HI_Y), 8'd128, 8'd128}};
      tbl[7] = '{2'd0, 24'hFF0000, {8'd77, 8'd85, 8'(HI_C)}};
      tbl[8] = '{2'd0, 24'h0000FF, {8'd29, 8'(HI_C), 8'd107}};
      tbl[9] = '{2'd0, 24'h00FF00, {8'd149, 8'd43, 8'd21}};

      // Reset with junk on the inputs
      pixel_in = 24'hA5A5A5;
      de       = 1'b1;
      vsync    = 1'b1;
      rst      = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) apply_vec(tbl[i]);

      // Mode request mid-frame is ignored until the next vsync rise
      apply_vec(tbl[0]);
      mode_in = 2'd1;
      repeat (4) cycle();
      chk("midframe pixel", 32'(pixel_out), 32'(P601));
      chk("midframe mode", 32'(mode_active), 32'd0);
      vsync    = 1'b0;
      pixel_in = 24'h000000;
      cycle();
      vsync    = 1'b1;
      pixel_in = P;
      cycle();
      chk("edge mode", 32'(mode_active), 32'd1);
      pixel_in = 24'hFFFFFF;
      cycle();
      chk("pre-edge pixel", 32'(pixel_out), 32'({8'(LO), 8'd128, 8'd128}));
      cycle();
      chk("edge pixel", 32'(pixel_out), 32'(P709));

      // One-cycle reset mid-stream, then first vsync counts as a rise
      rst = 1'b1;
      cycle();
      chk("midrst pixel", 32'(pixel_out), 32'h0);
      chk("midrst mode", 32'(mode_active), 32'd0);
      rst      = 1'b0;
      vsync    = 1'b1;
      de       = 1'b1;
      hsync    = 1'b0;
      mode_in  = 2'd1;
      pixel_in = P;
      cycle();
      chk("resume p1", 32'(pixel_out), 32'h0);
      chk("resume mode", 32'(mode_active), 32'd1);
      cycle();
      chk("resume p2", 32'(pixel_out), 32'h0);
      cycle();
      chk("resume p3", 32'(pixel_out), 32'(P709));
      chk("resume de", 32'(de_out), 32'd1);

      // Random traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         pixel_in = 24'($urandom);
         de       = 1'($urandom);
         hsync    = 1'($urandom);
         mode_in  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) vsync = ~vsync;
         rst = ($urandom_range(0, 63) == 0);
         cycle();
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rgb2ycbcr_csc.md
Name: rgb2ycbcr_csc

Overview:
Parametrised, pipelined colour-space converter for the video pipeline. It converts RGB to YCbCr using BT.601 or BT.709 full-range coefficients, or passes pixels through unchanged.
- Sits between the HDMI/DVI receive path and downstream processing.
- Carries de/hsync/vsync delay-matched to the pixel.
- The conversion mode can be changed at runtime; changes take effect only on frame boundaries.

Parameters:
DATA_W, 8, bits per colour component (8..12)
MODE_DEFAULT, 0, mode loaded at reset (0=BT.601, 1=BT.709, 2/3=bypass)

Ports:
clk  in  1  pixel clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
mode_in  in  2  requested mode, sampled at frame start
de  in  1  data enable
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
pixel_in  in  3*DATA_W  {R,G,B}, R in MSBs
de_out  out  1  de delayed by pipeline latency
hsync_out  out  1  hsync delayed by pipeline latency
vsync_out  out  1  vsync delayed by pipeline latency
pixel_out  out  3*DATA_W  {Y,Cb,Cr}, Y in MSBs; {R,G,B} in bypass
mode_active  out  2  mode currently applied at the input stage

Behaviour:
- Reset (rst=1 at a clk edge):
  - All pipeline registers, de_out, hsync_out, vsync_out and pixel_out go to 0.
  - mode_active loads MODE_DEFAULT.
  - The vsync edge detector register clears to 0.
- Latency: fixed 3 cycles in every mode, including bypass. Sync/de outputs equal the inputs delayed 3 cycles.
- Mode switch:
  - Frame start is the rising edge of vsync (vsync=1 while the previous sample was 0).
  - On that cycle, mode_active takes mode_in, and the new mode applies to the pixel sampled on that same cycle.
  - mode_in changes at any other time are ignored.
  - The applied mode travels down the pipeline with each pixel, so no output pixel mixes coefficients.
  - First vsync after reset: the previous vsync sample is 0, so vsync=1 on that first cycle counts as a rising edge.
- Pipeline stages:
  - Stage 1: nine signed products of component x coefficient. Components are zero-extended unsigned; coefficients are 9-bit signed, scale 256.
  - Stage 2: three sums, each at least DATA_W+10 bits signed. Adds offset C0=(1<<(DATA_W-1))<<8 to Cb and Cr only, plus rounding constant 128 to all three.
  - Stage 3: arithmetic shift right by 8, then clamp to [0, 2^DATA_W-1].
- Coefficients (Y ; Cb ; Cr, each as R,G,B):
  - BT.601: 77,150,29 ; -43,-85,128 ; 128,-107,-21
  - BT.709: 54,183,19 ; -29,-99,128 ; 128,-116,-12
- Bypass: pixel_in is delayed 3 cycles unmodified. No clamping; the RANGE_LIMIT_EN clamp also does not apply.
- Blanking: conversion runs regardless of de. Pixels with de=0 are still converted; downstream ignores them.
- Reset mid-frame: the pipeline flushes to zero. The mode returns to MODE_DEFAULT until the next vsync rising edge.

Optional Feature:
Macro CSC_RANGE_LIMIT_EN.
- When defined, non-bypass outputs are clamped to studio range after stage 3, with bounds scaled by 2^(DATA_W-8):
  - Y to [16,235]
  - Cb and Cr to [16,240]
- Latency remains 3 cycles.
- When undefined, the full range [0, 2^DATA_W-1] is used.

Test Plan:
- DATA_W=8, reset then vsync pulse with mode_in=0; pixel {128,255,28}, de=hsync=vsync=1 held -> 3 cycles later pixel_out={191,36,83}, sync outputs=1.
- Same pixel, mode_in=1 at vsync rising edge -> pixel_out={211,29,75}, mode_active=1.
- Mode change mid-frame: mode_in 0->1 while vsync stays high -> output stays BT.601 ({191,36,83}). After vsync 0->1, the first pixel sampled on the edge cycle exits as {211,29,75} exactly 3 cycles later.
- Bypass (mode 2): {128,255,28} -> pixel_out={128,255,28} after 3 cycles. White {255,255,255} in mode 0 -> {255,128,128}.
- Black {0,0,0}, mode 0 -> {0,128,128}. With CSC_RANGE_LIMIT_EN defined -> {16,128,128}. White with the macro -> {235,128,128}.
- Assert rst for 1 cycle mid-stream -> the next cycle shows all outputs 0 and mode_active=MODE_DEFAULT. Valid converted output resumes 3 cycles after inputs resume.
